// File: rtl/sd_pkg.sv
// Shared constants and helpers for the sd_multi_order sigma-delta modulator.
package sd_pkg;

    localparam int unsigned MAX_W     = 128;
    localparam int unsigned SAT_CNT_W = 16;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // x^16+x^14+x^13+x^11+1 expressed as bit positions of a right-shifting register
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [MAX_W-1:0] sat_max(input int unsigned width);
        return (MAX_W'(1) << (width - 1)) - MAX_W'(1);
    endfunction

    // Sign-extended most-negative value; slice to width to use.
    function automatic logic [MAX_W-1:0] sat_min(input int unsigned width);
        return ~sat_max(width);
    endfunction

    function automatic logic [MAX_W-1:0] fb_mag(input int unsigned shift);
        return MAX_W'(1) << shift;
    endfunction

endpackage

// File: rtl/sd_sat_adder.sv
// Two's-complement saturating adder; clamp is high when the result was limited.
module sd_sat_adder
    import sd_pkg::*;
#(
    parameter int unsigned BITWIDTH = 40
) (
    input  logic signed [BITWIDTH-1:0] a,
    input  logic signed [BITWIDTH-1:0] b,
    output logic signed [BITWIDTH-1:0] sum,
    output logic                       clamp
);

    localparam logic [BITWIDTH-1:0] SAT_MAX = BITWIDTH'(sat_max(BITWIDTH));
    localparam logic [BITWIDTH-1:0] SAT_MIN = BITWIDTH'(sat_min(BITWIDTH));

    logic [BITWIDTH:0] full;

    always_comb begin
        full  = {a[BITWIDTH-1], a} + {b[BITWIDTH-1], b};
        sum   = full[BITWIDTH-1:0];
        clamp = 1'b0;
        // Overflow shows as disagreement between the guard bit and the result sign.
        if (full[BITWIDTH] != full[BITWIDTH-1]) begin
            clamp = 1'b1;
            sum   = full[BITWIDTH] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/sd_multi_order.sv
// First/second-order saturating sigma-delta modulator with req/ack coefficient select.
// Optional input dither is enabled by defining SD_MULTI_ORDER_DITHER_EN.
module sd_multi_order
    import sd_pkg::*;
#(
    parameter int unsigned         BITWIDTH = 40,
    parameter int unsigned         NUM_K    = 4,
    parameter int unsigned         SEL_W    = 2,
    parameter int unsigned         FB_SHIFT = 16,
    parameter logic [BITWIDTH-1:0] RESETVAL = '0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic                      order2,
    input  logic [NUM_K*BITWIDTH-1:0] k_flat,
    input  logic [SEL_W-1:0]          sel,
    input  logic                      k_upd_req,
    output logic                      k_upd_ack,
    output logic                      sd_out,
    output logic                      sat_flag,
    output logic [SAT_CNT_W-1:0]      sat_cnt
);

    localparam logic signed [BITWIDTH-1:0] FB_POS = BITWIDTH'(fb_mag(FB_SHIFT));
    localparam logic signed [BITWIDTH-1:0] FB_NEG = -FB_POS;

    logic signed [BITWIDTH-1:0] acc1_q, acc2_q;
    logic [SEL_W-1:0]           idx_q;
    logic                       ack_q, sd_q, flag_q;
    logic [SAT_CNT_W-1:0]       cnt_q;

    logic [BITWIDTH-1:0]        k_words [NUM_K];
    logic signed [BITWIDTH-1:0] k_in, fb, s1a, acc1_n, s2a, acc2_n, q;
    logic [SEL_W-1:0]           sel_eff;
    logic                       c_k, c_1, c_f, c_2, clamp_any;

    always_comb begin
        for (int i = 0; i < NUM_K; i++) begin
            k_words[i] = k_flat[i*BITWIDTH +: BITWIDTH];
        end
    end

    always_comb begin
        sel_eff = sel;
        if (32'(sel) >= NUM_K) begin
            sel_eff = SEL_W'(NUM_K - 1);
        end
    end

`ifdef SD_MULTI_ORDER_DITHER_EN
    logic [15:0] lfsr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lfsr_q <= LFSR_SEED;
        end else if (en) begin
            lfsr_q <= {^(lfsr_q & LFSR_TAPS), lfsr_q[15:1]};
        end
    end

    assign k_in = k_words[idx_q] + (lfsr_q[0] ? BITWIDTH'(1) : {BITWIDTH{1'b1}});
`else
    assign k_in = k_words[idx_q];
`endif

    assign fb = sd_q ? FB_NEG : FB_POS;

    sd_sat_adder #(.BITWIDTH(BITWIDTH)) u_add_k (.a(k_in),   .b(fb),     .sum(s1a),    .clamp(c_k));
    sd_sat_adder #(.BITWIDTH(BITWIDTH)) u_add_1 (.a(s1a),    .b(acc1_q), .sum(acc1_n), .clamp(c_1));
    sd_sat_adder #(.BITWIDTH(BITWIDTH)) u_add_f (.a(acc1_q), .b(fb),     .sum(s2a),    .clamp(c_f));
    sd_sat_adder #(.BITWIDTH(BITWIDTH)) u_add_2 (.a(s2a),    .b(acc2_q), .sum(acc2_n), .clamp(c_2));

    // Stage-2 adders only count while the second-order path is actually in use.
    assign clamp_any = c_k | c_1 | (order2 & (c_f | c_2));
    assign q         = order2 ? acc2_q : acc1_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q <= '0;
            ack_q <= 1'b0;
        end else if (k_upd_req && !ack_q) begin
            idx_q <= sel_eff;
            ack_q <= 1'b1;
        end else if (!k_upd_req) begin
            ack_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc1_q <= RESETVAL;
            acc2_q <= '0;
            sd_q   <= 1'b0;
            flag_q <= 1'b0;
            cnt_q  <= '0;
        end else if (en) begin
            acc1_q <= acc1_n;
            acc2_q <= order2 ? acc2_n : '0;
            sd_q   <= ~q[BITWIDTH-1];
            if (clamp_any) begin
                flag_q <= 1'b1;
                if (cnt_q != '1) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign k_upd_ack = ack_q;
    assign sd_out    = sd_q;
    assign sat_flag  = flag_q;
    assign sat_cnt   = cnt_q;

endmodule
